// File: rtl/saber_pkg.sv
// Shared definitions for the saber sprite reader: default geometry, ROM address
// field widths and the frame index type.
package saber_pkg;

  localparam int unsigned SPR_W_DEF      = 32;
  localparam int unsigned SPR_H_DEF      = 32;
  localparam int unsigned NUM_FRAMES_DEF = 32;
  localparam int unsigned PIX_W_DEF      = 4;
  localparam int unsigned TRANSP_IDX_DEF = 0;

  // ROM address is {frame, row, col}
  localparam int unsigned FRAME_W = 5;
  localparam int unsigned ROW_W   = 5;
  localparam int unsigned COL_W   = 5;
  localparam int unsigned ADDR_W  = FRAME_W + ROW_W + COL_W;

  typedef logic [FRAME_W-1:0] saber_frame_t;

endpackage

// File: rtl/saber_edge_detect.sv
// Rising-edge detector for a level strobe that is synchronous to clk_i.
// Ports:
//   clk_i   - clock
//   rst_i   - asynchronous active-high reset (clears the delayed copy)
//   level_i - level signal to watch
//   rise_o  - one-cycle pulse while level_i is high and was low last cycle
module saber_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic level_i,
  output logic rise_o
);

  logic level_delayed_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_delayed_q <= 1'b0;
    end else begin
      level_delayed_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_delayed_q;

endmodule

// File: rtl/saber_frame_reader.sv
// Saber sprite reader. Latches the animation frame once per video frame, maps
// the current pixel into the sprite box, addresses the sprite ROM and returns
// a registered palette index plus an opaque flag.
// Ports:
//   Clk, Reset            - clock, asynchronous active-high reset
//   frame_clk             - per-frame level strobe (rising edge latches frame)
//   saber_state           - frame index from the animation FSM
//   facing_left           - mirror the sprite horizontally
//   saber_x, saber_y      - sprite top-left corner
//   DrawX, DrawY          - current pixel
//   rom_addr / rom_data   - sprite ROM port, data ROM_LAT cycles after address
//   pixel_idx, pixel_valid- palette index and opaque-and-in-box flag
//   cur_frame             - frame index currently in use
module saber_frame_reader
  import saber_pkg::*;
#(
  parameter int unsigned SPR_W      = SPR_W_DEF,
  parameter int unsigned SPR_H      = SPR_H_DEF,
  parameter int unsigned NUM_FRAMES = NUM_FRAMES_DEF,
  parameter int unsigned PIX_W      = PIX_W_DEF,
  parameter int unsigned ROM_LAT    = 1,
  parameter int unsigned TRANSP_IDX = TRANSP_IDX_DEF
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              frame_clk,
  input  logic [5:0]        saber_state,
  input  logic              facing_left,
  input  logic [9:0]        saber_x,
  input  logic [9:0]        saber_y,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [PIX_W-1:0]  rom_data,
  output logic [PIX_W-1:0]  pixel_idx,
  output logic              pixel_valid,
  output saber_frame_t      cur_frame
);

  logic             frame_rise;
  saber_frame_t     cur_frame_q, cur_frame_d;
  logic [10:0]      dx, dy;
  logic             inbox;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ROM_LAT-1:0] inbox_q, inbox_d;
  logic             inbox_late;
  logic [PIX_W-1:0] pixel_idx_q, pixel_idx_d;
  logic             pixel_valid_q, pixel_valid_d;

  saber_edge_detect u_frame_edge (
    .clk_i   (Clk),
    .rst_i   (Reset),
    .level_i (frame_clk),
    .rise_o  (frame_rise)
  );

  always_comb begin
    cur_frame_d = cur_frame_q;
    if (frame_rise) begin
      // Out-of-range animation states fall back to frame 0
      cur_frame_d = (saber_state < 6'(NUM_FRAMES)) ? saber_state[FRAME_W-1:0] : '0;
    end

    // 11-bit subtraction: bit 10 flags a pixel left of / above the box
    dx    = {1'b0, DrawX} - {1'b0, saber_x};
    dy    = {1'b0, DrawY} - {1'b0, saber_y};
    inbox = ~dx[10] & ~dy[10] & (dx[9:0] < 10'(SPR_W)) & (dy[9:0] < 10'(SPR_H));
    col   = facing_left ? (COL_W'(SPR_W - 1) - dx[COL_W-1:0]) : dx[COL_W-1:0];
    row   = dy[ROW_W-1:0];

    // The frame used is the one latched before this cycle's rise, if any
    rom_addr_d = inbox ? {cur_frame_q, row, col} : {cur_frame_q, {(ROW_W + COL_W){1'b0}}};

    // inbox rides a delay line so it lines up with the ROM word
    inbox_d    = ROM_LAT'({inbox_q, inbox});
    inbox_late = inbox_q[ROM_LAT-1];

    pixel_idx_d   = inbox_late ? rom_data : '0;
    pixel_valid_d = inbox_late & (rom_data != PIX_W'(TRANSP_IDX));
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cur_frame_q   <= '0;
      rom_addr_q    <= '0;
      inbox_q       <= '0;
      pixel_idx_q   <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      cur_frame_q   <= cur_frame_d;
      rom_addr_q    <= rom_addr_d;
      inbox_q       <= inbox_d;
      pixel_idx_q   <= pixel_idx_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  assign cur_frame   = cur_frame_q;
  assign rom_addr    = rom_addr_q;
  assign pixel_idx   = pixel_idx_q;
  assign pixel_valid = pixel_valid_q;

endmodule

// File: tb/tb_saber_frame_reader.sv
// Bench for saber_frame_reader: directed literal checks plus randomized
// streaming, all compared every cycle against a behavioural pixel model.
module tb_saber_frame_reader;

  logic        Clk;
  logic        Reset;
  logic        frame_clk;
  logic [5:0]  saber_state;
  logic        facing_left;
  logic [9:0]  saber_x, saber_y, DrawX, DrawY;
  logic [14:0] rom_addr;
  logic [3:0]  rom_data;
  logic [3:0]  pixel_idx;
  logic        pixel_valid;
  logic [4:0]  cur_frame;

  logic [3:0] rom_mem [0:32767];

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural expectations
  int         m_frame   = 0;
  logic       m_fc_prev = 1'b0;
  int         m_addr    = 0;
  int         m_pend_idx = 0;
  logic       m_pend_val = 1'b0;
  int         m_idx     = 0;
  logic       m_val     = 1'b0;

  saber_frame_reader dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .frame_clk   (frame_clk),
    .saber_state (saber_state),
    .facing_left (facing_left),
    .saber_x     (saber_x),
    .saber_y     (saber_y),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pixel_idx   (pixel_idx),
    .pixel_valid (pixel_valid),
    .cur_frame   (cur_frame)
  );

  // Synchronous ROM whose address register is rom_addr itself
  assign rom_data = rom_mem[rom_addr];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: pixel rules in plain integer arithmetic
  initial begin : model
    int   dxi, dyi, c, a, pix;
    logic in_box;
    forever begin
      @(posedge Clk or posedge Reset);
      if (Reset) begin
        m_frame = 0; m_fc_prev = 1'b0; m_addr = 0;
        m_pend_idx = 0; m_pend_val = 1'b0; m_idx = 0; m_val = 1'b0;
      end else begin
        m_idx = m_pend_idx;
        m_val = m_pend_val;
        dxi = int'(DrawX) - int'(saber_x);
        dyi = int'(DrawY) - int'(saber_y);
        in_box = (dxi >= 0) && (dxi < 32) && (dyi >= 0) && (dyi < 32);
        c = facing_left ? 31 - dxi : dxi;
        a = m_frame * 1024 + (in_box ? dyi * 32 + c : 0);
        pix = in_box ? int'(rom_mem[a]) : 0;
        m_addr = a;
        m_pend_idx = pix;
        m_pend_val = in_box && (pix != 0);
        if (frame_clk && !m_fc_prev) m_frame = (saber_state < 32) ? int'(saber_state) : 0;
        m_fc_prev = frame_clk;
      end
    end
  end

  // Per-cycle comparison away from the active edge
  initial begin : compare
    forever begin
      @(negedge Clk);
      n_tests++;
      if (rom_addr !== 15'(m_addr) || pixel_idx !== 4'(m_idx) || pixel_valid !== m_val ||
          cur_frame !== 5'(m_frame)) begin
        n_fail++;
        $display("FAIL model t=%0t: addr=%h idx=%h val=%b frame=%0d, expected addr=%h idx=%h val=%b frame=%0d",
                 $time, rom_addr, pixel_idx, pixel_valid, cur_frame,
                 15'(m_addr), 4'(m_idx), m_val, m_frame);
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic rise(input logic [5:0] st);
    saber_state = st;
    frame_clk   = 1'b1;
    tick();
    frame_clk   = 1'b0;
  endtask

  // Issue one request, check the address, then the pixel one cycle later
  task automatic pin(input string nm, input logic [9:0] x, input logic [9:0] y,
                     input logic left, input logic [14:0] ea, input logic [3:0] ei,
                     input logic ev);
    DrawX = x; DrawY = y; facing_left = left;
    tick();
    check({nm, " addr"}, 32'(rom_addr), 32'(ea));
    DrawX = 10'd0; DrawY = 10'd0; facing_left = 1'b0;
    tick();
    check({nm, " idx"}, 32'(pixel_idx), 32'(ei));
    check({nm, " valid"}, 32'(pixel_valid), 32'(ev));
  endtask

  initial begin : driver
    int waited;
    for (int i = 0; i < 32768; i++) rom_mem[i] = 4'($urandom);
    rom_mem[15'h0C45] = 4'hA;
    rom_mem[15'h0C5A] = 4'h0;
    rom_mem[15'h0C5F] = 4'h5;
    rom_mem[15'h0045] = 4'h7;
    Reset = 1'b1; frame_clk = 1'b0; saber_state = 6'd0; facing_left = 1'b0;
    saber_x = 10'd100; saber_y = 10'd50; DrawX = 10'd0; DrawY = 10'd0;
    tick(); tick();
    check("reset addr", 32'(rom_addr), 32'd0);
    check("reset idx", 32'(pixel_idx), 32'd0);
    check("reset valid", 32'(pixel_valid), 32'd0);
    check("reset frame", 32'(cur_frame), 32'd0);
    Reset = 1'b0;
    tick();

    rise(6'd7);
    check("frame latch 7", 32'(cur_frame), 32'd7);
    saber_state = 6'd9;
    tick(); tick();
    check("frame held", 32'(cur_frame), 32'd7);

    rise(6'd3);
    pin("right", 10'd105, 10'd52, 1'b0, 15'h0C45, 4'hA, 1'b1);
    pin("left transp", 10'd105, 10'd52, 1'b1, 15'h0C5A, 4'h0, 1'b0);
    pin("edge in", 10'd131, 10'd52, 1'b0, 15'h0C5F, 4'h5, 1'b1);
    pin("edge out", 10'd132, 10'd52, 1'b0, 15'h0C00, 4'h0, 1'b0);
    pin("left of box", 10'd99, 10'd52, 1'b0, 15'h0C00, 4'h0, 1'b0);

    rise(6'd40);
    check("frame oob", 32'(cur_frame), 32'd0);

    // Sprite hanging off the right edge, full scanline streamed
    saber_x = 10'd620; saber_y = 10'd50; DrawY = 10'd60;
    for (int x = 0; x < 640; x++) begin
      DrawX = 10'(x);
      facing_left = (x >= 630);
      tick();
    end

    // Randomized traffic around the sprite
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        saber_x = 10'($urandom_range(0, 639));
        saber_y = 10'($urandom_range(0, 479));
        facing_left = 1'($urandom);
      end
      DrawX = 10'(int'(saber_x) + int'($urandom_range(0, 40)) - 4);
      DrawY = 10'(int'(saber_y) + int'($urandom_range(0, 40)) - 4);
      frame_clk = ($urandom_range(0, 7) == 0) ? ~frame_clk : frame_clk;
      saber_state = 6'($urandom);
      tick();
    end
    frame_clk = 1'b0;

    // Reset mid-stream while a pixel is being drawn
    saber_x = 10'd100; saber_y = 10'd50; facing_left = 1'b0;
    waited = 0;
    while (pixel_valid !== 1'b1 && waited < 64) begin
      DrawX = 10'(100 + (waited % 32)); DrawY = 10'd52;
      tick();
      waited++;
    end
    check("valid before reset", 32'(pixel_valid), 32'd1);
    #2 Reset = 1'b1;
    #1;
    check("async reset valid", 32'(pixel_valid), 32'd0);
    check("async reset addr", 32'(rom_addr), 32'd0);
    tick();
    Reset = 1'b0;
    pin("after reset", 10'd105, 10'd52, 1'b0, 15'h0045, 4'h7, 1'b1);
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
